// File: rtl/regpair_pkg.sv
// ---------------------------------------------------------------------------
// regpair_pkg
// Shared types for the register-pair file with increment/decrement unit.
//   op_e     : IDU operation codes as presented on the 2-bit op port
//   state_e  : sequencing states of the IDU
//   PAIR_*   : default pair indices (BC, DE, HL, WZ, PC, SP)
// ---------------------------------------------------------------------------
package regpair_pkg;

  typedef enum logic [1:0] {
    OP_LATCH = 2'b00,
    OP_INC   = 2'b01,
    OP_DEC   = 2'b10,
    OP_XCHG  = 2'b11
  } op_e;

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_UPDATE = 1'b1
  } state_e;

  localparam int PAIR_BC = 0;
  localparam int PAIR_DE = 1;
  localparam int PAIR_HL = 2;
  localparam int PAIR_WZ = 3;
  localparam int PAIR_PC = 4;
  localparam int PAIR_SP = 5;

endpackage

// File: rtl/regpair_idu.sv
// ---------------------------------------------------------------------------
// regpair_idu
// Combinational +/-1 on a W-bit operand, wrapping modulo 2^W.
//   op      in  op_e  OP_DEC subtracts one, every other code adds one
//   operand in  W     value to step
//   result  out W     stepped value
// ---------------------------------------------------------------------------
module regpair_idu
  import regpair_pkg::*;
#(
  parameter int W = 16
) (
  input  op_e          op,
  input  logic [W-1:0] operand,
  output logic [W-1:0] result
);

  // Only INC/DEC ever reach the writeback, so anything not DEC is INC.
  always_comb begin
    result = operand + W'(1);
    if (op == OP_DEC) begin
      result = operand - W'(1);
    end
  end

endmodule

// File: rtl/regpair_file_idu.sv
// ---------------------------------------------------------------------------
// regpair_file_idu
// NPAIRS register pairs of 2*DW bits with byte-lane access from the internal
// data bus, plus a handshaked increment/decrement unit that loads a
// registered address latch and writes the stepped value back to the pair.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   pair_sel          pair addressed by byte access and IDU ops
//   data_in           internal data bus write value
//   wr_hi, wr_lo      byte-lane writes of data_in into pair_sel
//   rd_hi, rd_lo      byte-lane reads of pair_sel (rd_hi wins)
//   data_out, data_oe registered read data and its valid/drive enable
//   op_valid, op      IDU request: LATCH, INC, DEC, XCHG
//   op_ready          high while the IDU is idle
//   op_done           one-cycle completion pulse
//   address           registered address latch towards the bus interface
//
// Build option: define REGPAIR_XCHG_EN to make op XCHG swap pair[DE_IDX]
// and pair[HL_IDX]; otherwise XCHG behaves exactly as LATCH.
// ---------------------------------------------------------------------------
module regpair_file_idu
  import regpair_pkg::*;
#(
  parameter int DW     = 8,
  parameter int NPAIRS = 6,
  parameter int DE_IDX = PAIR_DE,
  parameter int HL_IDX = PAIR_HL
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [$clog2(NPAIRS)-1:0] pair_sel,
  input  logic [DW-1:0]             data_in,
  input  logic                      wr_hi,
  input  logic                      wr_lo,
  input  logic                      rd_hi,
  input  logic                      rd_lo,
  output logic [DW-1:0]             data_out,
  output logic                      data_oe,
  input  logic                      op_valid,
  input  logic [1:0]                op,
  output logic                      op_ready,
  output logic                      op_done,
  output logic [2*DW-1:0]           address
);

  localparam int AW = 2 * DW;
  localparam int SW = $clog2(NPAIRS);
  localparam logic [SW-1:0] DE_SEL = SW'(DE_IDX);
  localparam logic [SW-1:0] HL_SEL = SW'(HL_IDX);

`ifdef REGPAIR_XCHG_EN
  localparam bit XCHG_EN = 1'b1;
`else
  localparam bit XCHG_EN = 1'b0;
`endif

  logic [AW-1:0] pairs [NPAIRS];
  state_e        state;
  op_e           cap_op;
  logic [SW-1:0] cap_sel;
  logic          cap_hit;
  logic [AW-1:0] idu_result;

  op_e           op_in;
  logic          sel_hit;
  logic [AW-1:0] sel_value;
  logic          accept;
  logic          is_step;
  logic          is_xchg;
  logic          is_latch;

  // Out-of-range selects read as zero and block every write to the array.
  assign op_in     = op_e'(op);
  assign sel_hit   = (int'(pair_sel) < NPAIRS);
  assign sel_value = sel_hit ? pairs[pair_sel] : '0;

  assign op_ready = (state == S_IDLE);
  assign accept   = op_valid && op_ready;
  assign is_step  = accept && ((op_in == OP_INC) || (op_in == OP_DEC));
  assign is_xchg  = accept && XCHG_EN && (op_in == OP_XCHG);
  assign is_latch = accept && !is_step && !is_xchg;

  // The IDU steps the latched address, so the latch keeps the pre-update
  // value while the pair receives the stepped one.
  regpair_idu #(
    .W(AW)
  ) u_idu (
    .op      (cap_op),
    .operand (address),
    .result  (idu_result)
  );

  // Pair array, read port, address latch and IDU sequencing. Byte writes
  // are applied last so their lane overrides an IDU writeback or a swap
  // landing on the same pair in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NPAIRS; i++) begin
        pairs[i] <= '0;
      end
      address  <= '0;
      data_out <= '0;
      data_oe  <= 1'b0;
      op_done  <= 1'b0;
      state    <= S_IDLE;
      cap_op   <= OP_LATCH;
      cap_sel  <= '0;
      cap_hit  <= 1'b0;
    end else begin
      op_done <= 1'b0;

      data_oe <= rd_hi | rd_lo;
      if (rd_hi) begin
        data_out <= sel_value[AW-1:DW];
      end else if (rd_lo) begin
        data_out <= sel_value[DW-1:0];
      end

      case (state)
        S_IDLE: begin
          if (is_step) begin
            address <= sel_value;
            cap_op  <= op_in;
            cap_sel <= pair_sel;
            cap_hit <= sel_hit;
            state   <= S_UPDATE;
          end else if (is_latch) begin
            address <= sel_value;
            op_done <= 1'b1;
          end else if (is_xchg) begin
            pairs[DE_SEL] <= pairs[HL_SEL];
            pairs[HL_SEL] <= pairs[DE_SEL];
            op_done       <= 1'b1;
          end
        end
        S_UPDATE: begin
          if (cap_hit) begin
            pairs[cap_sel] <= idu_result;
          end
          op_done <= 1'b1;
          state   <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase

      if (sel_hit) begin
        if (wr_hi) begin
          pairs[pair_sel][AW-1:DW] <= data_in;
        end
        if (wr_lo) begin
          pairs[pair_sel][DW-1:0] <= data_in;
        end
      end
    end
  end

endmodule

// File: tb/tb_regpair_file_idu.sv
// ---------------------------------------------------------------------------
// tb_regpair_file_idu
// Self-checking bench for regpair_file_idu: directed scenarios followed by
// random traffic, every cycle compared against a behavioural model that
// keeps the pairs as plain integers.
// ---------------------------------------------------------------------------
module tb_regpair_file_idu;

  localparam int NP = 6;

`ifdef REGPAIR_XCHG_EN
  localparam bit XCHG = 1'b1;
`else
  localparam bit XCHG = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  pair_sel;
  logic [7:0]  data_in;
  logic        wr_hi, wr_lo, rd_hi, rd_lo;
  logic [7:0]  data_out;
  logic        data_oe;
  logic        op_valid;
  logic [1:0]  op;
  logic        op_ready;
  logic        op_done;
  logic [15:0] address;

  int n_compared   = 0;
  int n_mismatched = 0;

  // Behavioural model state
  int m_pairs [8];
  int m_addr, m_dout, m_psel;
  bit m_oe, m_done, m_busy, m_pdec;

  regpair_file_idu #(
    .DW(8), .NPAIRS(NP), .DE_IDX(1), .HL_IDX(2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .pair_sel (pair_sel),
    .data_in  (data_in),
    .wr_hi    (wr_hi),
    .wr_lo    (wr_lo),
    .rd_hi    (rd_hi),
    .rd_lo    (rd_lo),
    .data_out (data_out),
    .data_oe  (data_oe),
    .op_valid (op_valid),
    .op       (op),
    .op_ready (op_ready),
    .op_done  (op_done),
    .address  (address)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advances the model by one clock edge using the inputs the DUT sampled.
  task automatic modelStep();
    int nxt [8];
    int v, s, d;
    s = int'(pair_sel);
    d = int'(data_in);
    if (rst) begin
      for (int i = 0; i < 8; i++) m_pairs[i] = 0;
      m_addr = 0; m_dout = 0; m_oe = 0; m_done = 0; m_busy = 0;
      return;
    end
    nxt = m_pairs;
    m_done = 0;
    v = (s < NP) ? m_pairs[s] : 0;
    m_oe = rd_hi || rd_lo;
    if (rd_hi) m_dout = v / 256;
    else if (rd_lo) m_dout = v % 256;
    if (m_busy) begin
      if (m_psel < NP) nxt[m_psel] = m_pdec ? (m_addr + 65535) % 65536 : (m_addr + 1) % 65536;
      m_done = 1;
      m_busy = 0;
    end else if (op_valid) begin
      if (op == 2'd1 || op == 2'd2) begin
        m_addr = v; m_busy = 1; m_psel = s; m_pdec = (op == 2'd2);
      end else if (op == 2'd3 && XCHG) begin
        nxt[1] = m_pairs[2]; nxt[2] = m_pairs[1]; m_done = 1;
      end else begin
        m_addr = v; m_done = 1;
      end
    end
    if (s < NP) begin
      if (wr_hi) nxt[s] = d * 256 + nxt[s] % 256;
      if (wr_lo) nxt[s] = (nxt[s] / 256) * 256 + d;
    end
    m_pairs = nxt;
  endtask

  // Drives one cycle of inputs, clocks it, and compares every output.
  task automatic applyStimulus(input bit r, input int sel, input int din,
                               input bit whi, input bit wlo, input bit rhi, input bit rlo,
                               input bit ov, input int opc);
    rst = r; pair_sel = 3'(sel); data_in = 8'(din);
    wr_hi = whi; wr_lo = wlo; rd_hi = rhi; rd_lo = rlo;
    op_valid = ov; op = 2'(opc);
    @(posedge clk);
    modelStep();
    #1;
    checkOutput("data_out", 32'(data_out), 32'(m_dout));
    checkOutput("data_oe",  32'(data_oe),  32'(m_oe));
    checkOutput("address",  32'(address),  32'(m_addr));
    checkOutput("op_done",  32'(op_done),  32'(m_done));
    checkOutput("op_ready", 32'(op_ready), 32'(!m_busy));
  endtask

  initial begin
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("rst_addr",  32'(address),  32'h0);
    checkOutput("rst_ready", 32'(op_ready), 32'h1);
    for (int i = 0; i < NP; i++) begin
      applyStimulus(0, i, 0, 0, 0, i % 2 == 0, i % 2 == 1, 0, 0);
      checkOutput("rst_read", {23'h0, data_oe, data_out}, 32'h100);
    end

    // Fetch-then-increment on pair 4
    applyStimulus(0, 4, 8'h12, 1, 0, 0, 0, 0, 0);
    applyStimulus(0, 4, 8'h34, 0, 1, 0, 0, 0, 0);
    applyStimulus(0, 4, 0, 0, 0, 0, 0, 1, 1);
    checkOutput("inc_addr",  32'(address),  32'h1234);
    checkOutput("inc_busy",  32'(op_ready), 32'h0);
    applyStimulus(0, 4, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("inc_done",  32'(op_done),  32'h1);
    checkOutput("inc_ready", 32'(op_ready), 32'h1);
    applyStimulus(0, 4, 0, 0, 0, 0, 1, 0, 0);
    checkOutput("inc_once",  32'(op_done),  32'h0);
    checkOutput("inc_lo",    32'(data_out), 32'h35);

    // Wrap in both directions on pair 5
    applyStimulus(0, 5, 0, 1, 1, 0, 0, 0, 0);
    applyStimulus(0, 5, 0, 0, 0, 0, 0, 1, 2);
    checkOutput("dec_addr", 32'(address), 32'h0);
    applyStimulus(0, 5, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 5, 0, 0, 0, 1, 0, 1, 1);
    checkOutput("dec_wrap", 32'(data_out), 32'hFF);
    checkOutput("wrap_addr", 32'(address), 32'hFFFF);
    applyStimulus(0, 5, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 5, 0, 0, 0, 1, 0, 0, 0);
    checkOutput("inc_wrap", 32'(data_out), 32'h00);

    // Byte write and read of the captured pair during its update cycle
    applyStimulus(0, 2, 8'h00, 1, 0, 0, 0, 0, 0);
    applyStimulus(0, 2, 8'hFF, 0, 1, 0, 0, 0, 0);
    applyStimulus(0, 2, 0, 0, 0, 0, 0, 1, 1);
    applyStimulus(0, 2, 8'hAB, 1, 0, 1, 0, 0, 0);
    checkOutput("upd_read", 32'(data_out), 32'h00);
    applyStimulus(0, 2, 0, 0, 0, 1, 0, 0, 0);
    checkOutput("upd_hi", 32'(data_out), 32'hAB);
    applyStimulus(0, 2, 0, 0, 0, 0, 1, 0, 0);
    checkOutput("upd_lo", 32'(data_out), 32'h00);

    // Exchange DE/HL with pair_sel pointing elsewhere
    applyStimulus(0, 1, 8'h11, 1, 1, 0, 0, 0, 0);
    applyStimulus(0, 2, 8'h22, 1, 1, 0, 0, 0, 0);
    applyStimulus(0, 3, 8'h33, 1, 1, 0, 0, 0, 0);
    applyStimulus(0, 3, 0, 0, 0, 0, 0, 1, 3);
    checkOutput("xchg_addr", 32'(address), XCHG ? 32'h00FF : 32'h3333);
    applyStimulus(0, 1, 0, 0, 0, 1, 0, 0, 0);
    checkOutput("xchg_de", 32'(data_out), XCHG ? 32'h22 : 32'h11);
    applyStimulus(0, 2, 0, 0, 0, 0, 1, 0, 0);
    checkOutput("xchg_hl", 32'(data_out), XCHG ? 32'h11 : 32'h22);

    // Reset during the update cycle aborts the writeback
    applyStimulus(0, 0, 8'h01, 1, 1, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 1);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("abort_done",  32'(op_done),  32'h0);
    checkOutput("abort_ready", 32'(op_ready), 32'h1);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, 0);
    checkOutput("abort_pair", 32'(data_out), 32'h00);

    // Random traffic, including out-of-range selects and occasional reset
    for (int n = 0; n < 3000; n++) begin
      applyStimulus($urandom_range(0, 99) == 0, $urandom_range(0, 7), $urandom_range(0, 255),
                    $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                    $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                    $urandom_range(0, 2) == 0, $urandom_range(0, 3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
